mem_access_stage: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes that register's write index, write enable, mux select, ALU result, store data, PC and load/store flags.
- Loads and stores go to the data memory over a request/ready handshake. While an access is outstanding, the stage stalls upstream.
- Results are selected (ALU / memory / PC+4) and registered into the MEM/WB register that feeds register-file writeback.
- Timed-out and misaligned accesses are flagged.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_stage_if;
    logic [31:0] memAddr;
    logic [31:0] memWrData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memRdData;
    logic        memReady;

    modport master (
        output memAddr, memWrData, memRead, memWrite,
        input  memRdData, memReady
    );

    modport slave (
        input  memAddr, memWrData, memRead, memWrite,
        output memRdData, memReady
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores over a request/ready bus, stalls
// upstream while busy, and registers the selected writeback into MEM/WB.
module mem_access_stage #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                inWrtIndex,
    input  logic                      inRegWrEn,
    input  logic [1:0]                inMulSel,
    input  logic [31:0]               inAluOut,
    input  logic [31:0]               inData2Out,
    input  logic [31:0]               inPC,
    input  logic                      inIsLoad,
    input  logic                      inIsStore,
    output logic                      memStall,
    mem_access_stage_if.master        mem,
    output logic [3:0]                outWrtIndex,
    output logic                      outRegWrEn,
    output logic [31:0]               outWrtData,
    output logic [31:0]               outPC,
    output logic                      memError
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  idx_q, idx_d;
    logic        wen_q, wen_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    // Request context held for the whole access; the ALU value is addr_q.
    logic [3:0]  lat_idx_q, lat_idx_d;
    logic        lat_wen_q, lat_wen_d;
    logic [1:0]  lat_sel_q, lat_sel_d;
    logic [31:0] lat_pc_q, lat_pc_d;

    logic        is_mem;
    logic        aligned;
    logic        timed_out;

    function automatic logic [31:0] wb_mux(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] mdata, input logic [31:0] pc);
        case (sel)
            2'd1:    return mdata;
            2'd2:    return pc + 32'd4;
            default: return alu;
        endcase
    endfunction

    assign is_mem    = inIsLoad || inIsStore;
    assign aligned   = (inAluOut[1:0] == 2'b00);
    assign timed_out = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wen_d     = wen_q;
        wb_data_d = wb_data_q;
        pc_d      = pc_q;
        err_d     = err_q;
        lat_idx_d = lat_idx_q;
        lat_wen_d = lat_wen_q;
        lat_sel_d = lat_sel_q;
        lat_pc_d  = lat_pc_q;
        memStall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem && aligned) begin
                    memStall  = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = 8'd0;
                    addr_d    = inAluOut;
                    wdata_d   = inData2Out;
                    rd_d      = inIsLoad;
                    wr_d      = inIsStore;
                    lat_idx_d = inWrtIndex;
                    lat_wen_d = inRegWrEn;
                    lat_sel_d = inMulSel;
                    lat_pc_d  = inPC;
                    wen_d     = 1'b0;
                end else begin
                    // Misaligned accesses retire immediately with error data.
                    idx_d     = inWrtIndex;
                    pc_d      = inPC;
                    wen_d     = inRegWrEn && !inIsStore;
                    wb_data_d = wb_mux(inMulSel, inAluOut, is_mem ? ERR_DATA : 32'd0, inPC);
                    if (is_mem)
                        err_d = 1'b1;
                end
            end
            BUSY: begin
                memStall = !(mem.memReady || timed_out);
                if (mem.memReady || timed_out) begin
                    state_d   = IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    idx_d     = lat_idx_q;
                    pc_d      = lat_pc_q;
                    wen_d     = lat_wen_q && rd_q;
                    wb_data_d = wb_mux(lat_sel_q, addr_q,
                                       mem.memReady ? mem.memRdData : ERR_DATA, lat_pc_q);
                    if (!mem.memReady)
                        err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wen_q     <= 1'b0;
            wb_data_q <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            lat_idx_q <= '0;
            lat_wen_q <= 1'b0;
            lat_sel_q <= '0;
            lat_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            wen_q     <= wen_d;
            wb_data_q <= wb_data_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            lat_idx_q <= lat_idx_d;
            lat_wen_q <= lat_wen_d;
            lat_sel_q <= lat_sel_d;
            lat_pc_q  <= lat_pc_d;
        end
    end

    assign mem.memAddr   = addr_q;
    assign mem.memWrData = wdata_q;
    assign mem.memRead   = rd_q;
    assign mem.memWrite  = wr_q;
    assign outWrtIndex   = idx_q;
    assign outRegWrEn    = wen_q;
    assign outWrtData    = wb_data_q;
    assign outPC         = pc_q;
    assign memError      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a writeback scoreboard and a
// scripted memory responder; plus a hand-written reset-mid-access sequence.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  inWrtIndex;
    logic        inRegWrEn;
    logic [1:0]  inMulSel;
    logic [31:0] inAluOut, inData2Out, inPC;
    logic        inIsLoad, inIsStore;
    logic        memStall;
    logic [3:0]  outWrtIndex;
    logic        outRegWrEn;
    logic [31:0] outWrtData, outPC;
    logic        memError;

    mem_access_stage_if mif();

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn), .inMulSel(inMulSel),
        .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
        .inIsLoad(inIsLoad), .inIsStore(inIsStore),
        .memStall(memStall), .mem(mif.master),
        .outWrtIndex(outWrtIndex), .outRegWrEn(outRegWrEn), .outWrtData(outWrtData),
        .outPC(outPC), .memError(memError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic        wen;
        logic [1:0]  sel;
        logic [31:0] alu, d2, pc;
        logic        ld, st;
        int          wait_n;   // BUSY cycles before memReady; -1 = never
        logic [31:0] rd;
        logic        e_wen;
        logic [31:0] e_data;
        logic        chk_data;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic        wen;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] idx, input logic wen, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] d2, input logic [31:0] pc,
                                input logic ld, input logic st, input int wait_n, input logic [31:0] rd,
                                input logic e_wen, input logic [31:0] e_data, input logic chk_data,
                                input logic e_err);
        vec_t v;
        v.idx = idx; v.wen = wen; v.sel = sel; v.alu = alu; v.d2 = d2; v.pc = pc;
        v.ld = ld; v.st = st; v.wait_n = wait_n; v.rd = rd;
        v.e_wen = e_wen; v.e_data = e_data; v.chk_data = chk_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive_idle();
        inWrtIndex = '0; inRegWrEn = 1'b0; inMulSel = '0; inAluOut = '0;
        inData2Out = '0; inPC = '0; inIsLoad = 1'b0; inIsStore = 1'b0;
        mif.memReady = 1'b0; mif.memRdData = '0;
    endtask

    task automatic issue(input vec_t v);
        bit   acc;
        int   busy;
        int   exp_cycles;
        exp_t e;
        acc = (v.ld || v.st) && (v.alu[1:0] == 2'b00);
        @(negedge clk);
        inWrtIndex = v.idx; inRegWrEn = v.wen; inMulSel = v.sel; inAluOut = v.alu;
        inData2Out = v.d2; inPC = v.pc; inIsLoad = v.ld; inIsStore = v.st;
        mif.memReady = 1'b0;
        e.idx = v.idx; e.wen = v.e_wen; e.data = v.e_data; e.chk_data = v.chk_data;
        e.pc = v.pc; e.err = v.e_err;
        sb.push_back(e);
        #1 chk("stall_idle", 32'(memStall), 32'(acc));
        if (acc) begin
            @(posedge clk);
            busy = 0;
            forever begin
                @(negedge clk);
                mif.memReady  = (busy == v.wait_n);
                mif.memRdData = (busy == v.wait_n) ? v.rd : 32'h0BAD0BAD;
                #1;
                chk("busy_memRead", 32'(mif.memRead), 32'(v.ld));
                chk("busy_memWrite", 32'(mif.memWrite), 32'(v.st));
                chk("busy_memAddr", mif.memAddr, v.alu);
                chk("busy_bubble", 32'(outRegWrEn), 32'd0);
                if (v.st) chk("busy_memWrData", mif.memWrData, v.d2);
                if (!memStall) break;
                busy++;
                if (busy > 64) begin
                    chk("busy_bound", 32'(busy), 32'd64);
                    break;
                end
            end
            exp_cycles = (v.wait_n < 0) ? 16 : v.wait_n + 1;
            chk("busy_cycles", 32'(busy + 1), 32'(exp_cycles));
        end
        @(posedge clk);
        #1;
        mif.memReady = 1'b0;
        e = sb.pop_front();
        chk("wb_index", 32'(outWrtIndex), 32'(e.idx));
        chk("wb_regwren", 32'(outRegWrEn), 32'(e.wen));
        if (e.chk_data) chk("wb_data", outWrtData, e.data);
        chk("wb_pc", outPC, e.pc);
        chk("mem_error", 32'(memError), 32'(e.err));
        chk("done_memRead", 32'(mif.memRead), 32'd0);
        chk("done_memWrite", 32'(mif.memWrite), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_memAddr"}, mif.memAddr, 32'd0);
        chk({tag, "_memWrData"}, mif.memWrData, 32'd0);
        chk({tag, "_memRead"}, 32'(mif.memRead), 32'd0);
        chk({tag, "_memWrite"}, 32'(mif.memWrite), 32'd0);
        chk({tag, "_outWrtIndex"}, 32'(outWrtIndex), 32'd0);
        chk({tag, "_outRegWrEn"}, 32'(outRegWrEn), 32'd0);
        chk({tag, "_outWrtData"}, outWrtData, 32'd0);
        chk({tag, "_outPC"}, outPC, 32'd0);
        chk({tag, "_memError"}, 32'(memError), 32'd0);
        chk({tag, "_memStall"}, 32'(memStall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         idx  wen sel alu           d2        pc            ld st wait rd            e_wen e_data        chk e_err
        vecs.push_back(mk(4'd5, 1, 2'd0, 32'h1234,     32'h0,  32'h10,       0, 0, 0, 32'h0,        1, 32'h1234,     1, 0));
        vecs.push_back(mk(4'd3, 1, 2'd2, 32'h9,        32'h0,  32'h100,      0, 0, 0, 32'h0,        1, 32'h104,      1, 0));
        vecs.push_back(mk(4'd1, 1, 2'd2, 32'h9,        32'h0,  32'hFFFFFFFC, 0, 0, 0, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(4'd9, 0, 2'd3, 32'hAAAA5555, 32'h0,  32'h20,       0, 0, 0, 32'h0,        0, 32'hAAAA5555, 1, 0));
        vecs.push_back(mk(4'd2, 1, 2'd1, 32'h77,       32'h0,  32'h24,       0, 0, 0, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(4'd7, 1, 2'd1, 32'h40,       32'h0,  32'h28,       1, 0, 3, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 0));
        vecs.push_back(mk(4'd4, 1, 2'd0, 32'h80,       32'h55, 32'h2C,       0, 1, 0, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(4'd6, 1, 2'd0, 32'h100,      32'h0,  32'h30,       1, 0, 1, 32'h12345678, 1, 32'h100,      1, 0));
        vecs.push_back(mk(4'd8, 1, 2'd1, 32'h44,       32'h0,  32'h34,       1, 0, -1, 32'h0,       1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(4'd5, 1, 2'd0, 32'h5A5A,     32'h0,  32'h38,       0, 0, 0, 32'h0,        1, 32'h5A5A,     1, 1));
        vecs.push_back(mk(4'd10, 1, 2'd1, 32'h42,      32'h0,  32'h3C,       1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(4'd11, 1, 2'd0, 32'h43,      32'h9,  32'h40,       0, 1, 0, 32'h0,        0, 32'h0,        0, 1));

        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            issue(vecs[i]);

        // Reset during the second BUSY cycle of a never-answered load.
        @(negedge clk);
        inWrtIndex = 4'd12; inRegWrEn = 1'b1; inMulSel = 2'd1; inAluOut = 32'h48;
        inPC = 32'h44; inIsLoad = 1'b1; inIsStore = 1'b0; mif.memReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("rst_busy_memRead", 32'(mif.memRead), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(posedge clk);
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        issue(mk(4'd13, 1, 2'd0, 32'hBEEF, 32'h0, 32'h50, 0, 0, 0, 32'h0, 1, 32'hBEEF, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
